// File: rtl/uctl_debounce_pkg.sv
// uctl_debounce_pkg: state encoding and per-signal debounce defaults for the USB status debouncer.
package uctl_debounce_pkg;

    typedef enum logic {
        UCTL_DBNC_STABLE = 1'b0,
        UCTL_DBNC_CHECK  = 1'b1
    } uctl_dbnc_state_e;

    localparam int UCTL_DBNC_VBUS_CYCLES = 1000;
    localparam int UCTL_DBNC_ID_CYCLES   = 1000;
    localparam int UCTL_DBNC_IDLE_CYCLES = 1000;

endpackage

// File: rtl/uctl_debounce.sv
// uctl_debounce: accepts a level change after DEBOUNCE_CYCLES stable clocks and
// reports it as a clean level, one-cycle rise/fall pulses and a sticky change flag.
module uctl_debounce
    import uctl_debounce_pkg::*;
#(
    parameter int   CNT_W           = 16,
    parameter int   DEBOUNCE_CYCLES = UCTL_DBNC_VBUS_CYCLES,
    parameter logic INIT_VAL        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic dataIn,
    input  logic clrFlag,
    output logic dataOut,
    output logic risePulse,
    output logic fallPulse,
    output logic changeFlag
);

    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cycles
        $error("uctl_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    uctl_dbnc_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic differ, accept;
    logic data_nxt, rise_nxt, fall_nxt, flag_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UCTL_DBNC_STABLE;
            cnt        <= '0;
            dataOut    <= INIT_VAL;
            risePulse  <= 1'b0;
            fallPulse  <= 1'b0;
            changeFlag <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dataOut    <= data_nxt;
            risePulse  <= rise_nxt;
            fallPulse  <= fall_nxt;
            changeFlag <= flag_nxt;
        end
    end

    // Terminal compare happens before the increment, so cnt tops out at TERM and never wraps.
    always_comb begin
        differ    = dataIn != dataOut;
        accept    = (state == UCTL_DBNC_CHECK) && differ && (cnt == TERM);
        state_nxt = (differ && !accept) ? UCTL_DBNC_CHECK : UCTL_DBNC_STABLE;
        cnt_nxt   = !(differ && !accept) ? '0 :
                    (state == UCTL_DBNC_STABLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    end

    always_comb begin
        data_nxt = accept ? ~dataOut : dataOut;
        rise_nxt = accept && !dataOut;
        fall_nxt = accept && dataOut;
        flag_nxt = accept || (changeFlag && !clrFlag);
    end

endmodule

// File: tb/tb_uctl_debounce.sv
// tb_uctl_debounce: directed checks of the debouncer at DEBOUNCE_CYCLES=4, plus the 2 and 2^CNT_W corners.
module tb_uctl_debounce;

    logic clk = 1'b0, reset = 1'b1, clrFlag = 1'b0;
    logic d4 = 1'b0, d2 = 1'b0, d8 = 1'b0;
    logic o4, r4, f4, c4, o2, r2, f2, c2, o8, r8, f8, c8;
    int cyc = 0, n_vec = 0, n_err = 0;
    logic [3:0] e4, e2, e8;

    always #5 clk = ~clk;

    uctl_debounce #(.CNT_W(16), .DEBOUNCE_CYCLES(4), .INIT_VAL(1'b0)) dut4 (
        .clk(clk), .reset(reset), .dataIn(d4), .clrFlag(clrFlag),
        .dataOut(o4), .risePulse(r4), .fallPulse(f4), .changeFlag(c4));
    uctl_debounce #(.CNT_W(3), .DEBOUNCE_CYCLES(2), .INIT_VAL(1'b0)) dut2 (
        .clk(clk), .reset(reset), .dataIn(d2), .clrFlag(clrFlag),
        .dataOut(o2), .risePulse(r2), .fallPulse(f2), .changeFlag(c2));
    uctl_debounce #(.CNT_W(3), .DEBOUNCE_CYCLES(8), .INIT_VAL(1'b0)) dut8 (
        .clk(clk), .reset(reset), .dataIn(d8), .clrFlag(clrFlag),
        .dataOut(o8), .risePulse(r8), .fallPulse(f8), .changeFlag(c8));

    // Cycle k is the interval after the k-th rising edge; inputs driven in cycle k are sampled at edge k+1.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d4 = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            wait_until(k);
            n_vec++;
            if ({o4, r4, f4, c4} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%b exp=0000", k, {o4, r4, f4, c4});
            end
            n_vec++;
            if ({o8, r8, f8, c8} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_w3 cyc=%0d got=%b exp=0000", k, {o8, r8, f8, c8});
            end
        end
        reset = 1'b0;
        d4 = 1'b0;
    endtask

    task automatic test_rise();
        wait_until(10);
        d4 = 1'b1;
        for (int k = 11; k <= 16; k++) begin
            wait_until(k);
            e4 = (k < 14) ? 4'b0000 : (k == 14) ? 4'b1101 : 4'b1001;
            n_vec++;
            if ({o4, r4, f4, c4} !== e4) begin
                n_err++;
                $display("FAIL rise cyc=%0d got=%b exp=%b", k, {o4, r4, f4, c4}, e4);
            end
        end
    endtask

    task automatic test_fall_clear();
        wait_until(30);
        d4 = 1'b0;
        for (int k = 31; k <= 42; k++) begin
            wait_until(k);
            e4 = (k < 34) ? 4'b1001 : (k == 34) ? 4'b0011 : (k <= 40) ? 4'b0001 : 4'b0000;
            n_vec++;
            if ({o4, r4, f4, c4} !== e4) begin
                n_err++;
                $display("FAIL fall_clear cyc=%0d got=%b exp=%b", k, {o4, r4, f4, c4}, e4);
            end
            clrFlag = (k == 33 || k == 40);
        end
    endtask

    task automatic test_reset_mid_check();
        wait_until(50);
        d4 = 1'b1;
        for (int k = 51; k <= 58; k++) begin
            wait_until(k);
            e4 = (k < 57) ? 4'b0000 : (k == 57) ? 4'b1101 : 4'b1001;
            n_vec++;
            if ({o4, r4, f4, c4} !== e4) begin
                n_err++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", k, {o4, r4, f4, c4}, e4);
            end
            reset = (k == 52);
        end
    endtask

    task automatic test_glitch();
        wait_until(100);
        reset = 1'b1;
        for (int k = 101; k <= 125; k++) begin
            wait_until(k);
            reset = 1'b0;
            e4 = (k < 124) ? 4'b0000 : (k == 124) ? 4'b1101 : 4'b1001;
            n_vec++;
            if ({o4, r4, f4, c4} !== e4) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", k, {o4, r4, f4, c4}, e4);
            end
            d4 = (k == 101 || k == 113) ? 1'b0 : (k == 110 || k == 120) ? 1'b1 : d4;
        end
    endtask

    task automatic test_param_sweep();
        wait_until(140);
        d2 = 1'b1;
        d8 = 1'b1;
        for (int k = 141; k <= 188; k++) begin
            wait_until(k);
            e2 = (k < 142) ? 4'b0000 : (k == 142) ? 4'b1101 : (k < 152) ? 4'b1001 :
                 (k == 152) ? 4'b0011 : 4'b0001;
            e8 = (k < 148) ? 4'b0000 : (k == 148) ? 4'b1101 : (k < 158) ? 4'b1001 :
                 (k == 158) ? 4'b0011 : 4'b0001;
            n_vec++;
            if ({o2, r2, f2, c2} !== e2) begin
                n_err++;
                $display("FAIL sweep_d2 cyc=%0d got=%b exp=%b", k, {o2, r2, f2, c2}, e2);
            end
            n_vec++;
            if ({o8, r8, f8, c8} !== e8) begin
                n_err++;
                $display("FAIL sweep_d8 cyc=%0d got=%b exp=%b", k, {o8, r8, f8, c8}, e8);
            end
            if (k == 150) begin
                d2 = 1'b0;
                d8 = 1'b0;
            end
            d8 = (k == 170) ? 1'b1 : (k == 177) ? 1'b0 : d8;
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall_clear();
        test_reset_mid_check();
        test_glitch();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
